// File: rtl/io_event_pkg.sv
// Shared event codes and helpers for the IO event queue.
// Optional timestamps are enabled with IO_EVENT_TIMESTAMP_EN.
package io_event_pkg;

  localparam int EVT_W = 3;
  localparam int NSRC  = 8;

  localparam logic [EVT_W-1:0] EVT_CENTER   = 3'd0;
  localparam logic [EVT_W-1:0] EVT_EAST     = 3'd1;
  localparam logic [EVT_W-1:0] EVT_NORTH    = 3'd2;
  localparam logic [EVT_W-1:0] EVT_SOUTH    = 3'd3;
  localparam logic [EVT_W-1:0] EVT_WEST     = 3'd4;
  localparam logic [EVT_W-1:0] EVT_PUSH     = 3'd5;
  localparam logic [EVT_W-1:0] EVT_ROT_RIGHT = 3'd6;
  localparam logic [EVT_W-1:0] EVT_ROT_LEFT = 3'd7;

  // Lowest set bit wins; returns 0 for an empty vector.
  function automatic logic [EVT_W-1:0] prio_enc(
    input logic [NSRC-1:0] v
  );
    logic [EVT_W-1:0] r;
    r = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) r = EVT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO; a write into a full FIFO is accepted
// when a read retires an entry in the same cycle.
module event_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             rd_fire, wr_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/io_event_queue.sv
// Pending register, fixed-priority arbiter and FIFO for parser events.
// Define IO_EVENT_TIMESTAMP_EN to store a write-cycle timestamp per entry.
module io_event_queue
  import io_event_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic [4:0]          compass_buttons,
  input  logic                rotary_push,
  input  logic                rotary_event,
  input  logic                rotary_left,
  output logic                rd_valid,
  output logic [EVT_W-1:0]    rd_data,
  input  logic                rd_ready,
`ifdef IO_EVENT_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0] rd_timestamp,
`endif
  output logic [CW-1:0]       count,
  output logic                overflow,
  input  logic                overflow_clr
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1)
  begin : g_bad_cfg
    $error("io_event_queue: invalid DEPTH/TS_WIDTH");
  end

`ifdef IO_EVENT_TIMESTAMP_EN
  localparam int FW = EVT_W + TS_WIDTH;
  logic [TS_WIDTH-1:0] ts_q;
`else
  localparam int FW = EVT_W;
`endif

  logic [NSRC-1:0]  src, pending_q, pending_d, clr_mask;
  logic [EVT_W-1:0] sel;
  logic             overflow_q, overflow_d;
  logic             full, empty, pop, wr_en, drop;
  logic [FW-1:0]    wr_data, fifo_out;

  assign src = {rotary_event & rotary_left,
                rotary_event & ~rotary_left,
                rotary_push,
                compass_buttons};

  assign sel   = prio_enc(pending_q);
  assign pop   = ~empty & rd_ready;
  assign wr_en = (|pending_q) & (~full | pop);

  always_comb begin
    clr_mask = '0;
    if (wr_en) clr_mask[sel] = 1'b1;
    // A pulse landing on a bit being drained is a fresh event.
    pending_d  = (pending_q & ~clr_mask) | src;
    drop       = |(src & pending_q & ~clr_mask);
    overflow_d = drop | (overflow_q & ~overflow_clr);
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef IO_EVENT_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) ts_q <= '0;
    else        ts_q <= ts_q + 1'b1;
  end

  assign wr_data      = {sel, ts_q};
  assign rd_data      = fifo_out[FW-1 -: EVT_W];
  assign rd_timestamp = fifo_out[TS_WIDTH-1:0];
`else
  assign wr_data = sel;
  assign rd_data = fifo_out;
`endif

  event_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_b),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_ready),
    .rd_data (fifo_out),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign rd_valid = ~empty;
  assign overflow = overflow_q;

endmodule
